// File: rtl/bp_io_pkg.sv
// Shared types and defaults for the Bus Pirate I/O channel.
package bp_io_pkg;

    typedef enum logic [2:0] {
        REL,
        IN,
        OUT,
        ODR,
        TURN
    } st_t;

    localparam int CNT_W           = 4;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int TURN_CYCLES_DEF = 2;

endpackage

// File: rtl/bp_sync_chain.sv
// Parameterized metastability synchronizer; the full chain is exposed so
// the caller can look one stage ahead of the output flop.
module bp_sync_chain #(
    parameter int STAGES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              d,
    output logic [STAGES-1:0] q
);

    logic [STAGES-1:0] r_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else begin
            r_q <= {r_q[STAGES-2:0], d};
        end
    end

    assign q = r_q;

endmodule

// File: rtl/bp_io_channel.sv
// One Bus Pirate I/O channel: pad/buffer control FSM plus synchronized readback.
// Open-drain mode is compiled in only when BP_IO_OPEN_DRAIN_EN is defined.
module bp_io_channel
    import bp_io_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int TURN_CYCLES = TURN_CYCLES_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic oe,
    input  logic od,
    input  logic dir,
    input  logic din,
    output logic dout,
    output logic dout_rise,
    output logic dout_fall,
    output logic busy,
    output logic bufdir,
    output logic bufod,
    output logic pin_oe,
    output logic pin_dout,
    input  logic pin_din
);

`ifdef BP_IO_OPEN_DRAIN_EN
    localparam bit OD_EN = 1'b1;
`else
    localparam bit OD_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] TC_LOAD = CNT_W'(TURN_CYCLES - 1);

    st_t              r_st;
    st_t              w_nxt_st;
    st_t              w_req;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_nxt_cnt;

    logic r_busy, r_bufdir, r_bufod, r_pin_oe, r_pin_dout;
    logic w_busy, w_bufdir, w_bufod, w_pin_oe, w_pin_dout;

    logic [SYNC_STAGES-1:0] w_sync;
    logic                   r_rise, r_fall;

    always_comb begin
        w_req = REL;
        if (oe) begin
            if (!dir)
                w_req = IN;
            else if (OD_EN && od)
                w_req = ODR;
            else
                w_req = OUT;
        end
    end

    // Crossing between the input and output sides always goes through TURN.
    always_comb begin
        w_nxt_st  = r_st;
        w_nxt_cnt = r_cnt;
        if (w_req == REL) begin
            w_nxt_st = REL;
        end else begin
            case (r_st)
                REL, IN: begin
                    if (w_req == IN) begin
                        w_nxt_st = IN;
                    end else begin
                        w_nxt_st  = TURN;
                        w_nxt_cnt = TC_LOAD;
                    end
                end
                OUT, ODR: begin
                    if (w_req == IN) begin
                        w_nxt_st  = TURN;
                        w_nxt_cnt = TC_LOAD;
                    end else begin
                        w_nxt_st = w_req;
                    end
                end
                TURN: begin
                    if (r_cnt == '0)
                        w_nxt_st = w_req;
                    else
                        w_nxt_cnt = r_cnt - 1'b1;
                end
                default: w_nxt_st = REL;
            endcase
        end
    end

    always_comb begin
        w_busy     = 1'b0;
        w_bufdir   = 1'b0;
        w_bufod    = 1'b0;
        w_pin_oe   = 1'b0;
        w_pin_dout = 1'b0;
        case (w_nxt_st)
            OUT: begin
                w_bufdir   = 1'b1;
                w_pin_oe   = 1'b1;
                w_pin_dout = din;
            end
            ODR: begin
                w_bufod  = OD_EN;
                w_bufdir = ~din;
                w_pin_oe = ~din;
            end
            TURN:    w_busy = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_st       <= REL;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_bufdir   <= 1'b0;
            r_bufod    <= 1'b0;
            r_pin_oe   <= 1'b0;
            r_pin_dout <= 1'b0;
        end else begin
            r_st       <= w_nxt_st;
            r_cnt      <= w_nxt_cnt;
            r_busy     <= w_busy;
            r_bufdir   <= w_bufdir;
            r_bufod    <= w_bufod;
            r_pin_oe   <= w_pin_oe;
            r_pin_dout <= w_pin_dout;
        end
    end

    bp_sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (pin_din),
        .q     (w_sync)
    );

    // Edges are taken one stage early so the pulse lines up with dout.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_sync[SYNC_STAGES-2] & ~w_sync[SYNC_STAGES-1];
            r_fall <= ~w_sync[SYNC_STAGES-2] & w_sync[SYNC_STAGES-1];
        end
    end

    assign dout      = w_sync[SYNC_STAGES-1];
    assign dout_rise = r_rise;
    assign dout_fall = r_fall;
    assign busy      = r_busy;
    assign bufdir    = r_bufdir;
    assign bufod     = r_bufod;
    assign pin_oe    = r_pin_oe;
    assign pin_dout  = r_pin_dout;

endmodule

// File: tb/tb_bp_io_channel.sv
// Directed bench for bp_io_channel (defaults SYNC_STAGES=2, TURN_CYCLES=2).
module tb_bp_io_channel;
    import bp_io_pkg::*;

    logic clock = 1'b0;
    logic reset, oe, od, dir, din, pin_din;
    logic dout, dout_rise, dout_fall, busy, bufdir, bufod, pin_oe, pin_dout;

    int n_tot  = 0;
    int n_pass = 0;

    bp_io_channel u_dut (
        .clock     (clock),
        .reset     (reset),
        .oe        (oe),
        .od        (od),
        .dir       (dir),
        .din       (din),
        .dout      (dout),
        .dout_rise (dout_rise),
        .dout_fall (dout_fall),
        .busy      (busy),
        .bufdir    (bufdir),
        .bufod     (bufod),
        .pin_oe    (pin_oe),
        .pin_dout  (pin_dout),
        .pin_din   (pin_din)
    );

    always #5 clock = ~clock;

    // {busy, bufdir, bufod, pin_oe, pin_dout}
    function automatic logic [7:0] outs();
        return {3'b000, busy, bufdir, bufod, pin_oe, pin_dout};
    endfunction

    function automatic logic [7:0] rd();
        return {5'b00000, dout, dout_rise, dout_fall};
    endfunction

    function automatic logic [7:0] st();
        return 8'(u_dut.r_st);
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        // 1: reset with an output request pending
        reset = 1'b1; oe = 1'b1; od = 1'b0; dir = 1'b1;
        din = 1'b1; pin_din = 1'b0;
        tick(2);
        chk("rst_outs", outs(), 8'h00);
        chk("rst_rd", rd(), 8'h00);
        chk("rst_st", st(), 8'(REL));
        reset = 1'b0;
        tick(1);
        chk("rel_turn1", outs(), 8'h10);
        tick(1);
        chk("rel_turn2", outs(), 8'h10);
        tick(1);
        chk("rel_out", outs(), 8'h0B);
        chk("rel_out_st", st(), 8'(OUT));
        din = 1'b0;
        tick(1);
        chk("din_lat", outs(), 8'h0A);

        // OUT -> IN turnaround
        dir = 1'b0;
        tick(1);
        chk("o2i_turn", outs(), 8'h10);
        tick(2);
        chk("o2i_in", outs(), 8'h00);
        chk("o2i_st", st(), 8'(IN));

        // 2: input sampling
        pin_din = 1'b1;
        tick(1);
        chk("in_d1", rd(), 8'h00);
        tick(1);
        chk("in_rise", rd(), 8'h06);
        chk("in_pin_oe", {7'd0, pin_oe}, 8'h00);
        tick(1);
        chk("in_hold", rd(), 8'h04);
        pin_din = 1'b0;
        tick(1);
        pin_din = 1'b1;
        tick(1);
        chk("in_fall", rd(), 8'h01);
        pin_din = 1'b0;
        tick(1);
        chk("in_rise_b2b", rd(), 8'h06);
        tick(1);
        chk("in_fall_b2b", rd(), 8'h01);
        tick(1);
        chk("in_quiet", rd(), 8'h00);

        // 3: IN -> OUT turnaround
        din = 1'b1; dir = 1'b1;
        tick(1);
        chk("i2o_turn1", outs(), 8'h10);
        tick(1);
        chk("i2o_turn2", outs(), 8'h10);
        tick(1);
        chk("i2o_out", outs(), 8'h0B);

`ifdef BP_IO_OPEN_DRAIN_EN
        // 4: open-drain, switched directly from OUT
        od = 1'b1; din = 1'b0;
        tick(1);
        chk("odr_low", outs(), 8'h0E);
        chk("odr_st", st(), 8'(ODR));
        din = 1'b1;
        tick(1);
        chk("odr_rel", outs(), 8'h04);
`else
        // 6: od ignored
        od = 1'b1; din = 1'b1;
        tick(1);
        chk("nod_hi", outs(), 8'h0B);
        din = 1'b0;
        tick(1);
        chk("nod_lo", outs(), 8'h0A);
        chk("nod_st", st(), 8'(OUT));
`endif

        // 5: abort a turnaround
        od = 1'b0; dir = 1'b0;
        tick(1);
        chk("abort_turn", outs(), 8'h10);
        oe = 1'b0;
        tick(1);
        chk("abort_outs", outs(), 8'h00);
        chk("abort_st", st(), 8'(REL));
        tick(1);
        chk("abort_hold", outs(), 8'h00);

        // REL -> IN is immediate
        oe = 1'b1;
        tick(1);
        chk("rel_in_st", st(), 8'(IN));

        // re-latch during TURN without restarting the counter
        dir = 1'b1; din = 1'b1;
        tick(1);
        chk("rl_turn1", outs(), 8'h10);
        dir = 1'b0;
        tick(1);
        chk("rl_turn2", outs(), 8'h10);
        tick(1);
        chk("rl_in", outs(), 8'h00);
        chk("rl_in_st", st(), 8'(IN));

        // asynchronous reset mid-TURN
        dir = 1'b1;
        tick(1);
        chk("ar_turn", outs(), 8'h10);
        #2;
        reset = 1'b1; oe = 1'b0;
        #1;
        chk("ar_outs", outs(), 8'h00);
        chk("ar_st", st(), 8'(REL));
        reset = 1'b0;
        tick(1);
        chk("ar_after", outs(), 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
